// File: rtl/servo_pwm_pkg.sv
// Shared widths, state encoding and default timing for the servo PWM driver.
package servo_pwm_pkg;

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned DUTY_W  = 20;
  localparam int unsigned SERVO_W = 16;
  localparam int unsigned SUM_W   = DUTY_W + 2;

  localparam int unsigned DEF_PERIOD    = 1000000;
  localparam int unsigned DEF_CENTER    = 75000;
  localparam int unsigned DEF_DUTY_MIN  = 50000;
  localparam int unsigned DEF_DUTY_MAX  = 100000;
  localparam int unsigned DEF_SHIFT     = 0;
  localparam int unsigned DEF_TIMEOUT   = 4;
  localparam int unsigned DEF_SLEW_STEP = 500;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Move cur toward tgt by at most step; an all-ones step degenerates to a direct jump.
  function automatic logic [DUTY_W-1:0] slew_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] res;
    res = tgt;
    if ((tgt > cur) && ((tgt - cur) > step)) begin
      res = cur + step;
    end else if ((cur > tgt) && ((cur - tgt) > step)) begin
      res = cur - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_duty_map.sv
// Combinational controller-word to duty mapping: arithmetic shift, centre offset, saturation.
module servo_duty_map
  import servo_pwm_pkg::*;
#(
  parameter int unsigned CENTER   = DEF_CENTER,
  parameter int unsigned DUTY_MIN = DEF_DUTY_MIN,
  parameter int unsigned DUTY_MAX = DEF_DUTY_MAX,
  parameter int unsigned SHIFT    = DEF_SHIFT
) (
  input  logic signed [SERVO_W-1:0] servo,
  output logic        [DUTY_W-1:0]  duty_c
);

  localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER);
  localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(DUTY_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(DUTY_MAX);

  logic signed [SERVO_W-1:0] shifted;
  logic signed [SUM_W-1:0]   sum;

  // Sum is wide enough that the extreme controller words cannot wrap before clamping.
  always_comb begin
    shifted = servo >>> SHIFT;
    sum     = CENTER_S + $signed({{(SUM_W-SERVO_W){shifted[SERVO_W-1]}}, shifted});
    if (sum < MIN_S) begin
      duty_c = DUTY_W'(DUTY_MIN);
    end else if (sum > MAX_S) begin
      duty_c = DUTY_W'(DUTY_MAX);
    end else begin
      duty_c = DUTY_W'(sum);
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Servo PWM actuator: frame counter, shadow/active duty, watchdog park and sample strobe.
// Optional feature macro: SERVO_SLEW_EN limits the per-frame duty change to SLEW_STEP.
module servo_pwm_driver
  import servo_pwm_pkg::*;
#(
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned CENTER    = DEF_CENTER,
  parameter int unsigned DUTY_MIN  = DEF_DUTY_MIN,
  parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
  parameter int unsigned SHIFT     = DEF_SHIFT,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic                      clk_i,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic signed [SERVO_W-1:0] servo_i,
  input  logic                      dataf_i,
  output logic                      sample_o,
  output logic                      pwm_o,
  output logic        [DUTY_W-1:0]  duty_o,
  output logic                      fault_o
);

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam int unsigned       MISS_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] CENTER_D = DUTY_W'(CENTER);
  localparam logic [DUTY_W-1:0] STEP     = SLEW_EN ? DUTY_W'(SLEW_STEP) : {DUTY_W{1'b1}};

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [DUTY_W-1:0]   shadow, shadow_nx;
  logic [DUTY_W-1:0]   active, active_nx;
  logic [DUTY_W-1:0]   target;
  logic [DUTY_W-1:0]   d_c;
  logic [MISS_W-1:0]   miss, miss_nx;
  logic                seen, seen_nx;
  logic                fault_nx, pwm_nx, sample_nx;
  logic                boundary_c, silent_c;

  servo_duty_map #(
    .CENTER  (CENTER),
    .DUTY_MIN(DUTY_MIN),
    .DUTY_MAX(DUTY_MAX),
    .SHIFT   (SHIFT)
  ) u_map (
    .servo (servo_i),
    .duty_c(d_c)
  );

  assign duty_o = active;

  // State and datapath registers; reset parks the servo at centre with the output low.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state    <= ST_OFF;
      cnt      <= '0;
      shadow   <= CENTER_D;
      active   <= CENTER_D;
      miss     <= '0;
      seen     <= 1'b0;
      fault_o  <= 1'b0;
      pwm_o    <= 1'b0;
      sample_o <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      shadow   <= shadow_nx;
      active   <= active_nx;
      miss     <= miss_nx;
      seen     <= seen_nx;
      fault_o  <= fault_nx;
      pwm_o    <= pwm_nx;
      sample_o <= sample_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    shadow_nx  = shadow;
    active_nx  = active;
    target     = shadow;
    miss_nx    = miss;
    seen_nx    = seen;
    fault_nx   = fault_o;
    boundary_c = (state != ST_OFF) && (cnt == LAST);

    if (dataf_i) begin
      shadow_nx = d_c;
      miss_nx   = '0;
      seen_nx   = 1'b1;
      fault_nx  = 1'b0;
    end

    // A frame counts as silent only if no strobe arrived anywhere in it, boundary cycle included.
    silent_c = boundary_c && !seen && !dataf_i;
    if (boundary_c) begin
      seen_nx = 1'b0;
    end
    if (silent_c && (miss != MISS_W'(TIMEOUT))) begin
      miss_nx = miss + MISS_W'(1);
    end

    case (state)
      ST_OFF: begin
        if (enable_i) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (silent_c && (miss_nx == MISS_W'(TIMEOUT))) begin
          state_nx = ST_FAULT;
          fault_nx = 1'b1;
        end
      end
      ST_FAULT: begin
        if (dataf_i) state_nx = ST_RUN;
      end
      default: state_nx = ST_OFF;
    endcase
    if (!enable_i) begin
      state_nx = ST_OFF;
    end

    if ((state == ST_OFF) || boundary_c) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end

    // Boundary load: same-cycle strobe bypasses the shadow; a fault parks at centre.
    if (boundary_c) begin
      target = dataf_i ? d_c : shadow;
      if (state_nx == ST_FAULT) target = CENTER_D;
      active_nx = slew_toward(active, target, STEP);
    end

    if (state == ST_OFF) begin
      miss_nx = '0;
      seen_nx = 1'b0;
    end

    pwm_nx    = (state != ST_OFF) && enable_i && (cnt < active);
    sample_nx = (state_nx != ST_OFF) && (cnt_nx == '0);
  end

endmodule
